// File: rtl/ddr_pkg.sv
// Shared types and helpers for the DDR game-state frame sender.
package ddr_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    LEN,
    FLAGS,
    SCORE,
    STATUS,
    ARROWS,
    CSUM
  } state_e;

  localparam logic [7:0]  DEF_SYNC_BYTE = 8'hA5;
  localparam int unsigned CNT_W         = 8;

  // Number of bytes counted by the LEN field (flags + score + status + arrows).
  function automatic int unsigned payload_len(input int unsigned score_bytes,
                                              input int unsigned num_status,
                                              input int unsigned num_arrows,
                                              input int unsigned arrow_bytes);
    return 1 + score_bytes + num_status + num_arrows * arrow_bytes;
  endfunction

endpackage

// File: rtl/ddr_byte_mux.sv
// Picks the frame byte for a given state/counter out of the snapshot.
module ddr_byte_mux
  import ddr_pkg::*;
#(
  parameter int unsigned SCORE_BYTES = 2,
  parameter int unsigned NUM_STATUS  = 4,
  parameter int unsigned NUM_ARROWS  = 16,
  parameter int unsigned ARROW_BYTES = 2,
  parameter logic [7:0]  SYNC_BYTE   = DEF_SYNC_BYTE
) (
  input  state_e                                 state,
  input  logic [CNT_W-1:0]                       cnt,
  input  logic [1:0]                             flags,
  input  logic [SCORE_BYTES*8-1:0]               score,
  input  logic [NUM_STATUS*8-1:0]                status,
  input  logic [NUM_ARROWS*ARROW_BYTES*8-1:0]    arrows,
  input  logic [7:0]                             csum_neg,
  output logic [7:0]                             byte_c
);

  localparam int unsigned PAYLOAD_LEN = payload_len(SCORE_BYTES, NUM_STATUS, NUM_ARROWS, ARROW_BYTES);

  int unsigned cnt_idx;
  int unsigned arrow_idx;

  // Arrow entries go MSB first, so reverse the byte order inside each entry.
  always_comb begin
    cnt_idx   = 32'(cnt);
    arrow_idx = (cnt_idx / ARROW_BYTES) * ARROW_BYTES + (ARROW_BYTES - 1 - (cnt_idx % ARROW_BYTES));
    byte_c    = 8'h00;
    case (state)
      SYNC:    byte_c = SYNC_BYTE;
      LEN:     byte_c = 8'(PAYLOAD_LEN);
      FLAGS:   byte_c = {6'b0, flags};
      SCORE:   byte_c = score[(SCORE_BYTES - 1 - cnt_idx) * 8 +: 8];
      STATUS:  byte_c = status[cnt_idx * 8 +: 8];
      ARROWS:  byte_c = arrows[arrow_idx * 8 +: 8];
      CSUM:    byte_c = csum_neg;
      default: byte_c = 8'h00;
    endcase
  end

endmodule

// File: rtl/ddr_frame_sender.sv
// Snapshots a game-state frame on start and streams it byte-by-byte to the UART TX.
// Define DDR_FRAME_CSUM_EN to append a two's-complement checksum byte.
module ddr_frame_sender
  import ddr_pkg::*;
#(
  parameter int unsigned SCORE_BYTES = 2,
  parameter int unsigned NUM_STATUS  = 4,
  parameter int unsigned NUM_ARROWS  = 16,
  parameter int unsigned ARROW_BYTES = 2,
  parameter logic [7:0]  SYNC_BYTE   = DEF_SYNC_BYTE
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   start,
  input  logic                                   pause,
  input  logic                                   next_song,
  input  logic [SCORE_BYTES*8-1:0]               score,
  input  logic [NUM_STATUS*8-1:0]                status,
  input  logic [NUM_ARROWS*ARROW_BYTES*8-1:0]    arrows,
  input  logic                                   tx_ready,
  output logic [7:0]                             tx_data,
  output logic                                   tx_valid,
  output logic                                   busy,
  output logic                                   done
);

  localparam int unsigned PAYLOAD_LEN = payload_len(SCORE_BYTES, NUM_STATUS, NUM_ARROWS, ARROW_BYTES);
  localparam int unsigned SW          = SCORE_BYTES * 8;
  localparam int unsigned STW         = NUM_STATUS * 8;
  localparam int unsigned AW_ALL      = NUM_ARROWS * ARROW_BYTES * 8;

  localparam logic [CNT_W-1:0] SCORE_LAST  = CNT_W'(SCORE_BYTES - 1);
  localparam logic [CNT_W-1:0] STATUS_LAST = CNT_W'(NUM_STATUS - 1);
  localparam logic [CNT_W-1:0] ARROW_LAST  = CNT_W'(NUM_ARROWS * ARROW_BYTES - 1);

  if (PAYLOAD_LEN > 255) begin : g_len_chk
    $error("ddr_frame_sender: PAYLOAD_LEN %0d exceeds 255", PAYLOAD_LEN);
  end

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         flags_q, flags_d;
  logic [SW-1:0]      score_q, score_d;
  logic [STW-1:0]     status_q, status_d;
  logic [AW_ALL-1:0]  arrows_q, arrows_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               tx_valid_q, tx_valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               accept_c;
  logic               last_c;
  logic [7:0]         byte_c;
  logic [7:0]         csum_neg_c;

`ifdef DDR_FRAME_CSUM_EN
  logic [7:0]         csum_q, csum_d;
  assign csum_neg_c = 8'(-csum_d);
`else
  assign csum_neg_c = 8'h00;
`endif

  assign accept_c = tx_valid_q && tx_ready;

  // Next-state logic; every state holds until its byte is accepted.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    flags_d    = flags_q;
    score_d    = score_q;
    status_d   = status_q;
    arrows_d   = arrows_q;
    tx_valid_d = tx_valid_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    last_c     = 1'b0;
`ifdef DDR_FRAME_CSUM_EN
    csum_d     = csum_q;
`endif
    case (state_q)
      IDLE: begin
        // The cycle carrying done still counts as part of the old frame.
        if (start && !done_q) begin
          flags_d    = {pause, next_song};
          score_d    = score;
          status_d   = status;
          arrows_d   = arrows;
          state_d    = SYNC;
          cnt_d      = '0;
          busy_d     = 1'b1;
          tx_valid_d = 1'b1;
`ifdef DDR_FRAME_CSUM_EN
          csum_d     = 8'h00;
`endif
        end
      end
      SYNC:  if (accept_c) state_d = LEN;
      LEN:   if (accept_c) state_d = FLAGS;
      FLAGS: if (accept_c) begin
        state_d = SCORE;
        cnt_d   = '0;
      end
      SCORE: if (accept_c) begin
        if (cnt_q == SCORE_LAST) begin
          state_d = STATUS;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STATUS: if (accept_c) begin
        if (cnt_q == STATUS_LAST) begin
          state_d = ARROWS;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ARROWS: if (accept_c) begin
        if (cnt_q == ARROW_LAST) begin
`ifdef DDR_FRAME_CSUM_EN
          state_d = CSUM;
          cnt_d   = '0;
`else
          last_c  = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      CSUM:    if (accept_c) last_c = 1'b1;
      default: state_d = IDLE;
    endcase

    if (last_c) begin
      state_d    = IDLE;
      cnt_d      = '0;
      tx_valid_d = 1'b0;
      busy_d     = 1'b0;
      done_d     = 1'b1;
    end

`ifdef DDR_FRAME_CSUM_EN
    if (accept_c && (state_q inside {LEN, FLAGS, SCORE, STATUS, ARROWS})) begin
      csum_d = csum_q + tx_data_q;
    end
`endif
  end

  ddr_byte_mux #(
    .SCORE_BYTES (SCORE_BYTES),
    .NUM_STATUS  (NUM_STATUS),
    .NUM_ARROWS  (NUM_ARROWS),
    .ARROW_BYTES (ARROW_BYTES),
    .SYNC_BYTE   (SYNC_BYTE)
  ) u_byte_mux (
    .state    (state_d),
    .cnt      (cnt_d),
    .flags    (flags_d),
    .score    (score_d),
    .status   (status_d),
    .arrows   (arrows_d),
    .csum_neg (csum_neg_c),
    .byte_c   (byte_c)
  );

  // Register the byte for the upcoming state so tx_data is valid with tx_valid.
  assign tx_data_d = byte_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      flags_q    <= '0;
      score_q    <= '0;
      status_q   <= '0;
      arrows_q   <= '0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef DDR_FRAME_CSUM_EN
      csum_q     <= 8'h00;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      flags_q    <= flags_d;
      score_q    <= score_d;
      status_q   <= status_d;
      arrows_q   <= arrows_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef DDR_FRAME_CSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_ddr_frame_sender.sv
// Directed + randomized bench for ddr_frame_sender with a byte-list reference model.
module tb_ddr_frame_sender;

  localparam int unsigned SB = 2;
  localparam int unsigned NS = 4;
  localparam int unsigned NA = 16;
  localparam int unsigned AB = 2;
  localparam int unsigned PL = 1 + SB + NS + NA * AB;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 start;
  logic                 pause;
  logic                 next_song;
  logic [SB*8-1:0]      score;
  logic [NS*8-1:0]      status;
  logic [NA*AB*8-1:0]   arrows;
  logic                 tx_ready;
  logic [7:0]           tx_data;
  logic                 tx_valid;
  logic                 busy;
  logic                 done;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  ddr_frame_sender dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .pause     (pause),
    .next_song (next_song),
    .score     (score),
    .status    (status),
    .arrows    (arrows),
    .tx_ready  (tx_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference frame: the byte list a receiver should see for a given snapshot.
  task automatic build_expected(input logic p, input logic n, input logic [SB*8-1:0] sc,
                                input logic [NS*8-1:0] st, input logic [NA*AB*8-1:0] ar);
    int sum;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'(PL));
    exp_q.push_back({6'b0, p, n});
    for (int b = 0; b < int'(SB); b++) exp_q.push_back(sc[(int'(SB) - 1 - b) * 8 +: 8]);
    for (int i = 0; i < int'(NS); i++) exp_q.push_back(st[i * 8 +: 8]);
    for (int j = 0; j < int'(NA); j++)
      for (int b = 0; b < int'(AB); b++)
        exp_q.push_back(ar[j * int'(AB) * 8 + (int'(AB) - 1 - b) * 8 +: 8]);
`ifdef DDR_FRAME_CSUM_EN
    sum = 0;
    for (int i = 1; i < exp_q.size(); i++) sum += int'(exp_q[i]);
    exp_q.push_back(8'((256 - (sum % 256)) % 256));
`else
    sum = 0;
`endif
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // rmode: 0 ready high, 1 toggling, 2 random. poke: 1 score change, 2 start in ARROWS, 3 reset in STATUS.
  task automatic collect(input int rmode, input int poke, input string tag);
    int   cyc = 0;
    int   dones = 0;
    int   done_cyc = -1;
    int   post = 0;
    bit   poked = 0;
    bit   prev_stall = 0;
    logic [7:0] prev_data = 8'h00;
    got_q.delete();
    while (cyc < 2000) begin
      @(negedge clk);
      start = 1'b0;
      case (rmode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = (cyc % 2 == 0);
        default: tx_ready = 1'($urandom_range(0, 1));
      endcase
      if (cyc == 0) begin
        check({tag, "_first_valid"}, 32'(tx_valid), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd1);
      end
      if (prev_stall && dones == 0) begin
        check({tag, "_stall_data"}, 32'(tx_data), 32'(prev_data));
        check({tag, "_stall_valid"}, 32'(tx_valid), 32'd1);
      end
      if (poke == 1 && cyc == 2) score = 16'hFFFF;
      if (poke == 2 && !poked && got_q.size() == 12) begin
        start = 1'b1;
        poked = 1;
      end
      if (poke == 3 && got_q.size() == 6) begin
        rst_n = 1'b0;
        #1;
        check({tag, "_rst_valid"}, 32'(tx_valid), 32'd0);
        check({tag, "_rst_busy"}, 32'(busy), 32'd0);
        return;
      end
      if (done) begin
        dones++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (dones > 0) begin
        post++;
        check({tag, "_idle_valid"}, 32'(tx_valid), 32'd0);
        if (post >= 4) break;
      end
      if (tx_valid && tx_ready) got_q.push_back(tx_data);
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
      cyc++;
    end
    start = 1'b0;
    check({tag, "_done_seen"}, 32'(dones > 0), 32'd1);
    check({tag, "_done_count"}, 32'(dones), 32'd1);
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
    if (rmode == 0) check({tag, "_frame_cycles"}, 32'(done_cyc), 32'(exp_q.size()));
    check({tag, "_byte_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
`ifdef DDR_FRAME_CSUM_EN
    begin
      logic [7:0] s = 8'h00;
      for (int i = 1; i < got_q.size(); i++) s = s + got_q[i];
      check({tag, "_csum_zero"}, 32'(s), 32'd0);
    end
`endif
  endtask

  task automatic set_vector1();
    pause     = 1'b1;
    next_song = 1'b0;
    score     = 16'h1234;
    status    = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    for (int j = 0; j < int'(NA); j++) arrows[j * 16 +: 16] = 16'h0100 + 16'(j);
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    tx_ready  = 1'b1;
    pause     = 1'b0;
    next_song = 1'b0;
    score     = '0;
    status    = '0;
    arrows    = '0;
    repeat (3) @(negedge clk);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_valid", 32'(tx_valid), 32'd0);

    // Directed frame with ready held high.
    set_vector1();
    build_expected(pause, next_song, score, status, arrows);
    check("len_field", 32'(exp_q[1]), 32'(PL));
    pulse_start();
    collect(0, 0, "v1");

    // Same frame through a stalling receiver.
    set_vector1();
    build_expected(pause, next_song, score, status, arrows);
    pulse_start();
    collect(1, 0, "v1_toggle");

    // Input change after start must not leak into the frame.
    set_vector1();
    build_expected(pause, next_song, score, status, arrows);
    pulse_start();
    collect(0, 1, "score_chg");

    // start during ARROWS is dropped.
    set_vector1();
    build_expected(pause, next_song, score, status, arrows);
    pulse_start();
    collect(0, 2, "start_busy");
    repeat (4) begin
      @(negedge clk);
      check("no_second_frame", 32'(tx_valid), 32'd0);
    end

    // Reset while sending STATUS, then a full frame from SYNC.
    set_vector1();
    build_expected(pause, next_song, score, status, arrows);
    pulse_start();
    collect(0, 3, "mid_rst");
    @(negedge clk);
    check("rst_hold_valid", 32'(tx_valid), 32'd0);
    check("rst_hold_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_busy", 32'(busy), 32'd0);
    pulse_start();
    collect(0, 0, "after_rst");

    // Random snapshots with a randomly stalling receiver.
    for (int k = 0; k < 4; k++) begin
      pause     = 1'($urandom);
      next_song = 1'($urandom);
      score     = 16'($urandom);
      status    = $urandom;
      for (int w = 0; w < int'(NA * AB / 4); w++) arrows[w * 32 +: 32] = $urandom;
      build_expected(pause, next_song, score, status, arrows);
      pulse_start();
      collect(2, 0, $sformatf("rand%0d", k));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
